// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction-memory req/ack handshake and feeds IF/ID.
// Optional performance counters are enabled with IFU_PERF_CNT_EN.
`timescale 1ns/1ps
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   output logic [31:0] o_instruction_out,
   output logic [31:0] o_pc_out,
   output logic        o_fetch_valid,
`ifdef IFU_PERF_CNT_EN
   output logic [31:0] o_fetch_count,
   output logic [31:0] o_stall_count,
`endif
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pending_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc_out;
   logic        r_valid;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc;
   logic        r_skid_valid;

   logic        w_req;
   logic        w_consume;
   logic        w_slot_free;
   logic [31:0] w_pc_plus4;

   // Handshake: a request stays raised with a fixed address until the cycle
   // IMem_Ack is seen; the slot hands over at an edge where Fetch_Valid && !Stall.
   assign w_req       = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
   assign w_consume   = r_valid && !i_stall;
   assign w_slot_free = !r_valid || !i_stall;
   assign w_pc_plus4  = r_pc + 32'd4;

   // Reset drops the request immediately rather than waiting for the next edge.
   assign o_imem_req        = w_req && !i_rst;
   assign o_imem_addr       = r_pc;
   assign o_instruction_out = r_instr;
   assign o_pc_out          = r_pc_out;
   assign o_fetch_valid     = r_valid;
   assign o_dbg_state       = r_state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_FETCH;
         r_pc         <= RESET_PC;
         r_pending_pc <= RESET_PC;
         r_instr      <= 32'd0;
         r_pc_out     <= 32'd0;
         r_valid      <= 1'b0;
         r_skid_instr <= 32'd0;
         r_skid_pc    <= 32'd0;
         r_skid_valid <= 1'b0;
      end else if (i_redirect) begin
         r_valid      <= 1'b0;
         r_skid_valid <= 1'b0;
         if (w_req && !i_imem_ack) begin
            // The outstanding read must complete at its old address first.
            r_pending_pc <= i_redirect_pc;
            r_state      <= ST_DISCARD;
         end else begin
            r_pc    <= i_redirect_pc;
            r_state <= ST_FETCH;
         end
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (i_imem_ack) begin
                  r_pc <= w_pc_plus4;
                  if (w_slot_free) begin
                     r_instr  <= i_imem_data;
                     r_pc_out <= w_pc_plus4;
                     r_valid  <= 1'b1;
                  end else begin
                     r_skid_instr <= i_imem_data;
                     r_skid_pc    <= w_pc_plus4;
                     r_skid_valid <= 1'b1;
                     r_state      <= ST_HOLD;
                  end
               end else if (w_consume) begin
                  r_valid <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (w_consume) begin
                  r_instr      <= r_skid_instr;
                  r_pc_out     <= r_skid_pc;
                  r_valid      <= r_skid_valid;
                  r_skid_valid <= 1'b0;
                  r_state      <= ST_FETCH;
               end
            end
            ST_DISCARD: begin
               if (w_consume) begin
                  r_valid <= 1'b0;
               end
               if (i_imem_ack) begin
                  r_pc    <= r_pending_pc;
                  r_state <= ST_FETCH;
               end
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] r_fetch_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fetch_count <= 32'd0;
         r_stall_count <= 32'd0;
      end else begin
         if (w_consume) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
         if (r_valid && i_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign o_fetch_count = r_fetch_count;
   assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written redirect/wrap/reset
// sequences, and randomized phases checked against an instruction-stream reference model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        i_rst;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_data;
   logic [31:0] o_instruction_out;
   logic [31:0] o_pc_out;
   logic        o_fetch_valid;
   logic [1:0]  o_dbg_state;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] o_fetch_count;
   logic [31:0] o_stall_count;
`endif

   instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .i_clk             (clk),
      .i_rst             (i_rst),
      .i_stall           (i_stall),
      .i_redirect        (i_redirect),
      .i_redirect_pc     (i_redirect_pc),
      .o_imem_req        (o_imem_req),
      .o_imem_addr       (o_imem_addr),
      .i_imem_ack        (i_imem_ack),
      .i_imem_data       (i_imem_data),
      .o_instruction_out (o_instruction_out),
      .o_pc_out          (o_pc_out),
      .o_fetch_valid     (o_fetch_valid),
`ifdef IFU_PERF_CNT_EN
      .o_fetch_count     (o_fetch_count),
      .o_stall_count     (o_stall_count),
`endif
      .o_dbg_state       (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic do_reset();
      i_rst         = 1'b1;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'd0;
      repeat (2) @(posedge clk);
      #1 i_rst = 1'b0;
   endtask

   // ---------------- memory model + stream scoreboard ----------------
   int          mem_lat = 0;     // wait cycles before Ack; negative = random Ack
   int          mem_cnt = 0;
   logic [31:0] exp_addr = RESET_PC;
   logic        prev_pend = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   logic        redir_prev = 1'b0;
   int          consumed = 0;
   logic [31:0] m_fetch_cnt = 32'd0;
   logic [31:0] m_stall_cnt = 32'd0;

   initial begin
      i_imem_ack  = 1'b0;
      i_imem_data = 32'd0;
      forever begin
         @(negedge clk);
         if (o_imem_req) begin
            if (mem_lat < 0)            i_imem_ack = ($urandom_range(0, 2) == 0);
            else if (mem_cnt >= mem_lat) i_imem_ack = 1'b1;
            else                         i_imem_ack = 1'b0;
            if (i_imem_ack) mem_cnt = 0;
            else            mem_cnt++;
         end else begin
            i_imem_ack = 1'b0;
            mem_cnt    = 0;
         end
         i_imem_data = i_imem_ack ? mem_word(o_imem_addr) : ~mem_word(o_imem_addr);
         #1;
         if (i_rst) begin
            exp_addr    = RESET_PC;
            prev_pend   = 1'b0;
            redir_prev  = 1'b0;
            m_fetch_cnt = 32'd0;
            m_stall_cnt = 32'd0;
         end else begin
            if (redir_prev) chk("valid_after_redirect", 32'(o_fetch_valid), 32'd0);
            if (prev_pend) begin
               chk("req_held", 32'(o_imem_req), 32'd1);
               chk("addr_held", o_imem_addr, prev_addr);
            end
`ifdef IFU_PERF_CNT_EN
            chk("fetch_count", o_fetch_count, m_fetch_cnt);
            chk("stall_count", o_stall_count, m_stall_cnt);
`endif
            // The consumed stream must be the program order from the last redirect target.
            if (o_fetch_valid && !i_stall) begin
               chk("stream_instr", o_instruction_out, mem_word(exp_addr));
               chk("stream_pc", o_pc_out, exp_addr + 32'd4);
               exp_addr    = exp_addr + 32'd4;
               consumed++;
               m_fetch_cnt = m_fetch_cnt + 32'd1;
            end
            if (o_fetch_valid && i_stall) m_stall_cnt = m_stall_cnt + 32'd1;
            prev_pend  = o_imem_req && !i_imem_ack;
            prev_addr  = o_imem_addr;
            redir_prev = i_redirect;
            if (i_redirect) exp_addr = i_redirect_pc;
         end
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        stall;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc_out;
      logic [31:0] exp_instr;
   } vec_t;

   typedef struct {
      int lat;
      int stall_pct;
      int redir_pct;
      int cycles;
   } phase_t;

   vec_t   tv[8];
   phase_t ph[5];

   initial begin
      int found;
      int n10;
      int c0;

      tv[0] = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0};
      tv[1] = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd4,  mem_word(32'd0)};
      tv[2] = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd8,  mem_word(32'd4)};
      tv[3] = '{1'b1, 1'b0, 32'd12, 1'b1, 32'd8,  mem_word(32'd4)};
      tv[4] = '{1'b1, 1'b0, 32'd12, 1'b1, 32'd8,  mem_word(32'd4)};
      tv[5] = '{1'b0, 1'b0, 32'd12, 1'b1, 32'd8,  mem_word(32'd4)};
      tv[6] = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd12, mem_word(32'd8)};
      tv[7] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd16, mem_word(32'd12)};

      ph[0] = '{0,  0,  0, 100};
      ph[1] = '{0,  30, 5, 400};
      ph[2] = '{2,  40, 5, 400};
      ph[3] = '{-1, 30, 8, 500};
      ph[4] = '{1,  60, 10, 400};

      // zero-wait start-up followed by a 3-cycle stall over the Ack of address 8
      mem_lat = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         i_stall = tv[i].stall;
         @(negedge clk);
         #2;
         chk($sformatf("tv%0d_req", i),   32'(o_imem_req),    32'(tv[i].exp_req));
         chk($sformatf("tv%0d_addr", i),  o_imem_addr,        tv[i].exp_addr);
         chk($sformatf("tv%0d_valid", i), 32'(o_fetch_valid), 32'(tv[i].exp_valid));
         chk($sformatf("tv%0d_pc", i),    o_pc_out,           tv[i].exp_pc_out);
         chk($sformatf("tv%0d_instr", i), o_instruction_out,  tv[i].exp_instr);
         @(posedge clk);
         #1;
      end
      i_stall = 1'b0;

      // redirect in the first cycle of an outstanding 3-wait fetch of 0x10
      mem_lat = 3;
      do_reset();
      found = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (o_imem_addr == 32'h10) begin
            found = 1;
            break;
         end
      end
      chk("seq1_reach_10", 32'(found), 32'd1);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h100;
      @(posedge clk);
      #1 i_redirect = 1'b0;
      n10   = 0;
      found = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #2;
         if (o_imem_addr == 32'h100) begin
            found = 1;
            break;
         end
         if (o_imem_addr == 32'h10 && o_imem_req) n10++;
         chk("seq1_valid_low", 32'(o_fetch_valid), 32'd0);
      end
      chk("seq1_reach_100", 32'(found), 32'd1);
      chk("seq1_old_addr_cycles", 32'(n10), 32'd3);
      found = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #2;
         if (o_fetch_valid) begin
            found = 1;
            break;
         end
      end
      chk("seq1_target_valid", 32'(found), 32'd1);
      chk("seq1_target_pc", o_pc_out, 32'h104);
      chk("seq1_target_instr", o_instruction_out, mem_word(32'h100));

      // redirect coincident with a zero-wait Ack
      mem_lat = 0;
      do_reset();
      repeat (4) @(posedge clk);
      #1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h40;
      @(posedge clk);
      #1 i_redirect = 1'b0;
      @(negedge clk);
      #2;
      chk("seq2_valid_drop", 32'(o_fetch_valid), 32'd0);
      chk("seq2_addr", o_imem_addr, 32'h40);
      @(negedge clk);
      #2;
      chk("seq2_valid", 32'(o_fetch_valid), 32'd1);
      chk("seq2_pc", o_pc_out, 32'h44);
      chk("seq2_instr", o_instruction_out, mem_word(32'h40));

      // PC wrap at the top of the address space, then asynchronous reset mid-stream
      @(posedge clk);
      #1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'hFFFF_FFF8;
      @(posedge clk);
      #1 i_redirect = 1'b0;
      @(negedge clk);
      #2;
      chk("wrap_addr0", o_imem_addr, 32'hFFFF_FFF8);
      chk("wrap_valid0", 32'(o_fetch_valid), 32'd0);
      @(negedge clk);
      #2;
      chk("wrap_addr1", o_imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pc1", o_pc_out, 32'hFFFF_FFFC);
      @(negedge clk);
      #2;
      chk("wrap_addr2", o_imem_addr, 32'h0);
      chk("wrap_pc2", o_pc_out, 32'h0);
      chk("wrap_instr2", o_instruction_out, mem_word(32'hFFFF_FFFC));
      @(posedge clk);
      #3 i_rst = 1'b1;
      #1;
      chk("areset_valid", 32'(o_fetch_valid), 32'd0);
      chk("areset_pc", o_pc_out, 32'd0);
      chk("areset_instr", o_instruction_out, 32'd0);
      chk("areset_addr", o_imem_addr, RESET_PC);
      chk("areset_req", 32'(o_imem_req), 32'd0);
      repeat (2) @(posedge clk);
      #1 i_rst = 1'b0;
      @(negedge clk);
      #2;
      chk("post_reset_req", 32'(o_imem_req), 32'd1);

      // randomized phases against the stream model
      for (int p = 0; p < 5; p++) begin
         mem_lat = ph[p].lat;
         do_reset();
         c0 = consumed;
         for (int c = 0; c < ph[p].cycles; c++) begin
            i_stall    = ($urandom_range(0, 99) < ph[p].stall_pct);
            i_redirect = ($urandom_range(0, 99) < ph[p].redir_pct);
            if (i_redirect) begin
               if ($urandom_range(0, 3) == 0) i_redirect_pc = 32'hFFFF_FFF4;
               else                           i_redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            @(posedge clk);
            #1;
         end
         i_stall    = 1'b0;
         i_redirect = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("phase%0d_progress", p), 32'(consumed > c0), 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-stage front end of the five-stage pipeline: owns the PC, issues requests to instruction memory over a req/ack handshake, and presents fetched instruction plus PC+4 to the IF/ID stage register. Honours the pipeline stall (IF/ID write-enable low), accepts branch/jump redirects, and absorbs a stall that arrives mid-fetch with a one-entry skid buffer. Sits between instruction memory and the IF/ID register.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state
- Stall  in  1  high = IF/ID not accepting this cycle (inverse of IF/ID WriteEnable)
- Redirect  in  1  branch/jump taken; highest priority
- Redirect_PC  in  32  target address, valid with Redirect
- IMem_Req  out  1  fetch request, combinational from state
- IMem_Addr  out  32  fetch address, stable while IMem_Req high
- IMem_Ack  in  1  read done; IMem_Data valid this cycle; may be same cycle as IMem_Req
- IMem_Data  in  32  instruction word
- Instruction_Out  out  32  to IF/ID Instruction_In
- PC_Out  out  32  fetch address + 4, to IF/ID PC_In
- Fetch_Valid  out  1  Instruction_Out/PC_Out hold an unconsumed instruction

## Operation
- Registers: PC, Pending_PC, output slot (Instruction_Out, PC_Out, Fetch_Valid), skid (instr, pc, valid), state.
- Slot consumed at an edge when Fetch_Valid && !Stall. Slot free = !Fetch_Valid || !Stall.
- States: FETCH, HOLD, DISCARD. Reset state FETCH, PC = RESET_PC.
- FETCH: IMem_Req=1, IMem_Addr=PC. On Ack: slot free → slot <= {IMem_Data, PC+4, 1}, PC <= PC+4, stay; slot not free → skid <= {IMem_Data, PC+4}, PC <= PC+4, go HOLD. No Ack: hold request. If slot consumed without Ack, Fetch_Valid <= 0.
- HOLD: IMem_Req=0. On slot consumed: slot <= skid, skid cleared, go FETCH.
- Redirect (any state, overrides above): Fetch_Valid <= 0, skid cleared. If IMem_Req high and IMem_Ack low → Pending_PC <= Redirect_PC, go DISCARD. Else PC <= Redirect_PC, go FETCH; coincident Ack data dropped.
- DISCARD: IMem_Req=1, IMem_Addr=PC (old, unchanged). On Ack: data dropped, PC <= Pending_PC, go FETCH. Redirect in DISCARD overwrites Pending_PC only.
- A request once raised is never withdrawn or re-addressed before Ack.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0, PC_Out likewise.

## Timing
- Reset values: Instruction_Out=0, PC_Out=0, Fetch_Valid=0, skid empty, PC=RESET_PC, state FETCH; IMem_Req=1 once Reset deasserts.
- Zero-wait memory (Ack same cycle as Req): Fetch_Valid rises at first edge after reset release; one instruction per cycle sustained with Stall low.
- N-cycle Ack latency: slot loads at the Ack edge; throughput 1 per N+... cycles, no bubbles added by this block.
- Stall asserted at Ack edge with full slot: no data lost; skid drains first consumed edge after Stall falls; next request issues the cycle after.
- Redirect: first target instruction in slot at earliest one edge after target Ack; no wrong-path instruction ever has Fetch_Valid high after the Redirect edge.
- Reset mid-request: request abandoned immediately; memory must tolerate dropped IMem_Req.

## Configuration
- IFU_PERF_CNT_EN defined: adds outputs Fetch_Count (32, instructions consumed) and Stall_Count (32, edges with Fetch_Valid && Stall); both reset to 0, wrap at 2^32, Redirect does not clear.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, RESET_PC=0, zero-wait memory, Stall=0 → IMem_Addr 0,4,8,…; Instruction_Out follows memory one edge later; PC_Out 4,8,12; Fetch_Valid constant 1.
- Stall high 3 cycles while Ack arrives for addr 8 → slot holds addr 4 instr (PC_Out=8), HOLD with IMem_Req=0; Stall falls → addr 8 instr (PC_Out=12) next, then request addr 12; no instruction skipped or duplicated.
- Ack latency 3, Redirect to 32'h100 in cycle 1 of outstanding fetch of 0x10 → IMem_Addr stays 0x10 until Ack, data dropped, next IMem_Addr=0x100, Fetch_Valid low until 0x100 returns (PC_Out=0x104).
- Redirect coincident with Ack, target 0x40 → Ack data dropped, Fetch_Valid=0 next cycle, next IMem_Addr=0x40.
- PC at 32'hFFFF_FFFC, zero-wait → PC_Out=0, next IMem_Addr=0; Reset asserted mid-stream → all outputs at reset values asynchronously, IMem_Addr=RESET_PC.
- With IFU_PERF_CNT_EN: 10 consumed fetches plus 4 stalled edges → Fetch_Count=10, Stall_Count=4.
